// File: rtl/bus_ram_slave_pkg.sv
// -----------------------------------------------------------------------------
// bus_ram_slave_pkg
//
// Shared definitions for the bus RAM slave: the controller state encoding and
// the read latency, measured in clocks from the begin cycle to the first word
// that has dataValidOut set.
// -----------------------------------------------------------------------------
package bus_ram_slave_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        READ     = 3'd2,
        READ_END = 3'd3,
        ERROR    = 3'd4
    } state_t;

    // Latency from the begin cycle to the first read word on the bus. It is
    // one synchronous RAM cycle plus the output register.
    localparam int READ_LATENCY = 2;

endpackage

// File: rtl/dualPortSSRAM.sv
// -----------------------------------------------------------------------------
// dualPortSSRAM
//
// Generic dual-port synchronous static RAM. Both ports run on one clock. Each
// port has a registered read with one cycle of latency. A port that writes in
// a cycle returns the old contents of that address (read-first). If both ports
// write the same address in one cycle, port B wins.
//
// Ports:
//   clock                  : clock for both ports
//   writeEnableA/B         : write strobe per port
//   addressA/B             : word address per port
//   dataInA/B              : write data per port
//   dataOutA/B             : registered read data per port
// -----------------------------------------------------------------------------
module dualPortSSRAM #(
    parameter int bitwidth    = 32,
    parameter int nrOfEntries = 1024
) (
    input  logic                           clock,
    input  logic                           writeEnableA,
    input  logic [$clog2(nrOfEntries)-1:0] addressA,
    input  logic [bitwidth-1:0]            dataInA,
    output logic [bitwidth-1:0]            dataOutA,
    input  logic                           writeEnableB,
    input  logic [$clog2(nrOfEntries)-1:0] addressB,
    input  logic [bitwidth-1:0]            dataInB,
    output logic [bitwidth-1:0]            dataOutB
);

    logic [bitwidth-1:0] memory [nrOfEntries];

    // The storage array and both read registers have no reset. Memory contents
    // are kept across a reset.
    always_ff @(posedge clock) begin
        if (writeEnableA) begin
            memory[addressA] <= dataInA;
        end
        if (writeEnableB) begin
            memory[addressB] <= dataInB;
        end
        dataOutA <= memory[addressA];
        dataOutB <= memory[addressB];
    end

endmodule

// File: rtl/bus_ram_slave.sv
// -----------------------------------------------------------------------------
// bus_ram_slave
//
// A memory-mapped RAM that acts as a slave on the shared split-transaction bus.
// It decodes a window of 2^ADDR_BITS 32-bit words at BASE_ADDR and serves
// write and read bursts. Read bursts support busyIn back-pressure. A burst
// that would run past the end of the window is refused with a one-cycle
// errorOut pulse.
//
// Parameters:
//   BASE_ADDR  : bus byte address of the window (aligned to the window size)
//   ADDR_BITS  : width of the word index
//
// Ports:
//   clock, reset          : system clock; asynchronous active-high reset
//   beginTransactionIn    : start of a transaction; addressDataIn carries the address
//   endTransactionIn      : ends a write burst, or aborts a read burst
//   readNotWriteIn        : 1 = read burst, 0 = write burst
//   dataValidIn           : a write data word is present on addressDataIn
//   busyIn                : the master cannot take the read word this cycle
//   addressDataIn         : multiplexed address and data from the bus
//   byteEnablesIn         : byte lanes to write, latched at begin
//   burstSizeIn           : number of words in the burst, minus one
//   endTransactionOut     : read burst finished (one cycle)
//   dataValidOut          : read word present on addressDataOut
//   busyOut               : always 0; this slave never stalls the master
//   errorOut              : the burst was refused (one cycle)
//   addressDataOut        : read data; 0 whenever no word is being driven
// -----------------------------------------------------------------------------
module bus_ram_slave
    import bus_ram_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
    parameter int          ADDR_BITS = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic        endTransactionIn,
    input  logic        readNotWriteIn,
    input  logic        dataValidIn,
    input  logic        busyIn,
    input  logic [31:0] addressDataIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    output logic        endTransactionOut,
    output logic        dataValidOut,
    output logic        busyOut,
    output logic        errorOut,
    output logic [31:0] addressDataOut
);

    localparam int NR_WORDS  = 1 << ADDR_BITS;
    localparam int MAX_INDEX = NR_WORDS - 1;
    localparam int SUM_BITS  = ADDR_BITS + 9;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   index_q, index_d;
    logic [8:0]             count_q, count_d;
    logic [7:0]             burst_q, burst_d;
    logic [3:0]             be_q, be_d;
    logic [31:0]            data_out_q, data_out_d;
    logic                   valid_out_q, valid_out_d;
    logic                   end_out_q, end_out_d;
    logic                   error_q, error_d;
    logic                   busy_q, busy_d;

    logic [ADDR_BITS-1:0]   start_index;
    logic [SUM_BITS-1:0]    range_sum;
    logic                   range_error;
    logic                   selected;
    logic                   last_word;

    logic                   ram_we;
    logic [ADDR_BITS-1:0]   ram_addr_a;
    logic [31:0]            ram_data_a;
    logic [31:0]            ram_data_b;
    logic [31:0]            merged_word;

    assign start_index = addressDataIn[ADDR_BITS+1:2];
    assign selected    = beginTransactionIn &&
                         (addressDataIn[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);

    // The sum is computed wide enough that it cannot wrap. A burst that would
    // go past the top word is therefore always caught.
    assign range_sum   = SUM_BITS'(start_index) + SUM_BITS'(burstSizeIn);
    assign range_error = range_sum > SUM_BITS'(MAX_INDEX);

    assign last_word   = (count_q == {1'b0, burst_q});

    // Port A writes at the current index during a write burst. In every other
    // state it reads at the next index. The read data is then ready one cycle
    // later, when the output register needs it.
    assign ram_addr_a  = (state_q == WRITE) ? index_q : index_d;

    // Byte-lane merge. Port B always prefetches the word at index_d, so the
    // old contents of the word being written are already at ram_data_b. This
    // lets partial-word writes run back to back without a separate read cycle.
    // Port B never reads the address port A is writing in the same cycle.
    always_comb begin
        merged_word = ram_data_b;
        for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
                merged_word[8*b +: 8] = addressDataIn[8*b +: 8];
            end
        end
    end

    // Next-state and output logic. The bus outputs default to 0. Only READ,
    // READ_END and ERROR drive anything onto the wired-OR bus.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        count_d     = count_q;
        burst_d     = burst_q;
        be_d        = be_q;
        data_out_d  = 32'd0;
        valid_out_d = 1'b0;
        end_out_d   = 1'b0;
        error_d     = 1'b0;
        busy_d      = 1'b0;
        ram_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (selected) begin
                    burst_d = burstSizeIn;
                    be_d    = byteEnablesIn;
                    index_d = start_index;
                    count_d = 9'd0;
                    if (range_error) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else if (readNotWriteIn) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                // Words beyond the burst length are dropped silently.
                if (dataValidIn && (count_q <= {1'b0, burst_q})) begin
                    ram_we  = 1'b1;
                    index_d = index_q + ADDR_BITS'(1);
                    count_d = count_q + 9'd1;
                end
                if (endTransactionIn) begin
                    state_d = IDLE;
                end
            end

            READ: begin
                // index_q is the address whose data is on ram_data_a now.
                // It advances only when that word moves into the output
                // register. So the RAM re-reads the same word during a stall.
                if (endTransactionIn) begin
                    state_d = IDLE;
                end else if (!valid_out_q) begin
                    data_out_d  = ram_data_a;
                    valid_out_d = 1'b1;
                    index_d     = index_q + ADDR_BITS'(1);
                end else if (busyIn) begin
                    data_out_d  = data_out_q;
                    valid_out_d = 1'b1;
                end else begin
                    count_d = count_q + 9'd1;
                    if (last_word) begin
                        state_d   = READ_END;
                        end_out_d = 1'b1;
                    end else begin
                        data_out_d  = ram_data_a;
                        valid_out_d = 1'b1;
                        index_d     = index_q + ADDR_BITS'(1);
                    end
                end
            end

            READ_END: begin
                state_d = IDLE;
            end

            ERROR: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears them at once, without waiting
    // for a clock edge. Any transfer in progress is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            index_q     <= '0;
            count_q     <= '0;
            burst_q     <= '0;
            be_q        <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            end_out_q   <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            count_q     <= count_d;
            burst_q     <= burst_d;
            be_q        <= be_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            end_out_q   <= end_out_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
        end
    end

    assign endTransactionOut = end_out_q;
    assign dataValidOut      = valid_out_q;
    assign busyOut           = busy_q;
    assign errorOut          = error_q;
    assign addressDataOut    = data_out_q;

    dualPortSSRAM #(
        .bitwidth    (32),
        .nrOfEntries (NR_WORDS)
    ) u_ram (
        .clock        (clock),
        .writeEnableA (ram_we),
        .addressA     (ram_addr_a),
        .dataInA      (merged_word),
        .dataOutA     (ram_data_a),
        .writeEnableB (1'b0),
        .addressB     (index_d),
        .dataInB      (32'd0),
        .dataOutB     (ram_data_b)
    );

endmodule
